// File: rtl/pll_supervisor_pkg.sv
// Shared definitions for the PLL supervisor: FSM encoding, Gray/binary helpers
// and the nominal clock rates the default expected window count is derived from.
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_MEASURE,
    ST_CHECK,
    ST_REQ,
    ST_HOLDOFF
  } sup_state_t;

  localparam int SYS_CLK_KHZ  = 30720;
  localparam int PLL_CLK_KHZ  = 48000;
  localparam int DEF_WINDOW   = 1024;
  localparam int DEF_EXPECTED = (PLL_CLK_KHZ * DEF_WINDOW) / SYS_CLK_KHZ;

  function automatic logic [7:0] bin2gray(input logic [7:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [7:0] gray2bin(input logic [7:0] gray);
    logic [7:0] bin;
    bin[7] = gray[7];
    for (int i = 6; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/pll_sup_gray_cnt.sv
// Free-running 8-bit Gray counter clocked by the PLL output under test.
// Its output is sampled asynchronously: constrain gray -> synchroniser as a bus-skew/max-delay path.
module pll_sup_gray_cnt
  import pll_supervisor_pkg::*;
(
  input  logic       clk_48m,
  output logic [7:0] gray
);

  logic [7:0] gray_reg;

  // No reset: the supervisor only ever looks at differences between samples.
  always_ff @(posedge clk_48m) begin
    gray_reg <= bin2gray(gray2bin(gray_reg) + 8'd1);
  end

  assign gray = gray_reg;

endmodule

// File: rtl/pll_supervisor.sv
// Checks the 48 MHz PLL output by counting its edges over fixed windows of the 30.72 MHz clock.
// Define PLL_SUPERVISOR_AUTORESET_EN to request a PLL reset after repeated failed windows.
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int WINDOW    = DEF_WINDOW,
  parameter int EXPECTED  = DEF_EXPECTED,
`ifdef PLL_SUPERVISOR_AUTORESET_EN
  parameter int MAX_FAIL  = 3,
  parameter int RST_PULSE = 16,
  parameter int HOLDOFF   = 4096,
`endif
  parameter int TOL       = 16
) (
  input  logic        clk_30m72_i,
  input  logic        rst_30m72_i,
  input  logic        clk_48m,
  output logic        pll_rst_req,
  output logic        clk_ok,
  output logic [15:0] meas_cnt,
  output logic [3:0]  fail_cnt
);

  localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);
  localparam logic [16:0] LO_BOUND = (EXPECTED > TOL) ? 17'(EXPECTED - TOL) : 17'd0;
  localparam logic [16:0] HI_BOUND = 17'(EXPECTED + TOL);
`ifdef PLL_SUPERVISOR_AUTORESET_EN
  localparam logic [15:0] PULSE_LAST = 16'(RST_PULSE - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLDOFF - 1);
  localparam logic [3:0]  MAX_FAIL_V = 4'(MAX_FAIL);
`endif

  logic [7:0]  gray_48m;
  logic [7:0]  sync1_reg, sync2_reg;
  logic [7:0]  bin_now, bin_prev_reg, delta;
  logic [16:0] acc_sum;
  logic [15:0] acc_reg, acc_next;
  logic [15:0] timer_reg, timer_next;
  logic [15:0] meas_reg, meas_next;
  logic        ok_reg, ok_next;
  logic [3:0]  fail_reg, fail_next, fail_inc;
  logic        window_pass;
  sup_state_t  state_reg, state_next;

  pll_sup_gray_cnt u_gray_cnt (
    .clk_48m (clk_48m),
    .gray    (gray_48m)
  );

  always_ff @(posedge clk_30m72_i or posedge rst_30m72_i) begin
    if (rst_30m72_i) begin
      sync1_reg <= 8'd0;
      sync2_reg <= 8'd0;
    end else begin
      sync1_reg <= gray_48m;
      sync2_reg <= sync1_reg;
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_gray2bin
    assign bin_now[gi] = ^sync2_reg[7:gi];
  end

  // Modulo-256 difference absorbs the counter wrap.
  assign delta       = bin_now - bin_prev_reg;
  assign acc_sum     = {1'b0, acc_reg} + {9'd0, delta};
  assign fail_inc    = (fail_reg == 4'hF) ? 4'hF : fail_reg + 4'd1;
  assign window_pass = ({1'b0, acc_reg} >= LO_BOUND) && ({1'b0, acc_reg} <= HI_BOUND);

`ifdef PLL_SUPERVISOR_AUTORESET_EN
  logic req_reg, req_next;
`endif

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg + 16'd1;
    acc_next   = 16'd0;
    meas_next  = meas_reg;
    ok_next    = ok_reg;
    fail_next  = fail_reg;
`ifdef PLL_SUPERVISOR_AUTORESET_EN
    req_next   = 1'b0;
`endif
    case (state_reg)
      ST_SETTLE: begin
        if (timer_reg == WIN_LAST) begin
          state_next = ST_MEASURE;
          timer_next = 16'd0;
        end
      end
      ST_MEASURE: begin
        acc_next = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
        if (timer_reg == WIN_LAST) begin
          state_next = ST_CHECK;
          timer_next = 16'd0;
        end
      end
      ST_CHECK: begin
        meas_next  = acc_reg;
        ok_next    = window_pass;
        timer_next = 16'd0;
        state_next = ST_MEASURE;
        if (window_pass) begin
          fail_next = 4'd0;
        end else begin
          fail_next = fail_inc;
`ifdef PLL_SUPERVISOR_AUTORESET_EN
          if (fail_inc >= MAX_FAIL_V) begin
            state_next = ST_REQ;
            req_next   = 1'b1;
          end
`endif
        end
      end
`ifdef PLL_SUPERVISOR_AUTORESET_EN
      ST_REQ: begin
        fail_next = 4'd0;
        req_next  = 1'b1;
        if (timer_reg == PULSE_LAST) begin
          state_next = ST_HOLDOFF;
          timer_next = 16'd0;
          req_next   = 1'b0;
        end
      end
      ST_HOLDOFF: begin
        if (timer_reg == HOLD_LAST) begin
          state_next = ST_SETTLE;
          timer_next = 16'd0;
        end
      end
`endif
      default: begin
        state_next = ST_SETTLE;
        timer_next = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk_30m72_i or posedge rst_30m72_i) begin
    if (rst_30m72_i) begin
      state_reg    <= ST_SETTLE;
      timer_reg    <= 16'd0;
      acc_reg      <= 16'd0;
      meas_reg     <= 16'd0;
      ok_reg       <= 1'b0;
      fail_reg     <= 4'd0;
      bin_prev_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      acc_reg   <= acc_next;
      meas_reg  <= meas_next;
      ok_reg    <= ok_next;
      fail_reg  <= fail_next;
      // Holding bin_prev through CHECK folds that cycle's edges into the next window.
      if (state_reg != ST_CHECK) begin
        bin_prev_reg <= bin_now;
      end
    end
  end

`ifdef PLL_SUPERVISOR_AUTORESET_EN
  always_ff @(posedge clk_30m72_i or posedge rst_30m72_i) begin
    if (rst_30m72_i) begin
      req_reg <= 1'b0;
    end else begin
      req_reg <= req_next;
    end
  end
  assign pll_rst_req = req_reg;
`else
  assign pll_rst_req = 1'b0;
`endif

  assign clk_ok   = ok_reg;
  assign meas_cnt = meas_reg;
  assign fail_cnt = fail_reg;

endmodule

// File: tb/tb_pll_supervisor.sv
// Self-checking bench for pll_supervisor: a window-level model predicts counts and flags,
// with clk_48m frequency chosen per window from a table and at random.
module tb_pll_supervisor;

  localparam int SYS_HALF   = 16276;
  localparam int SYS_PERIOD = 2 * SYS_HALF;
  localparam int EXP_NOM    = 1600;
  localparam int TOL        = 16;
  localparam int H48M0      = 10417;
  localparam int H47M0      = 10638;
  localparam int H48M4      = 10331;
`ifdef PLL_SUPERVISOR_AUTORESET_EN
  localparam bit AUTORESET = 1'b1;
`else
  localparam bit AUTORESET = 1'b0;
`endif

  typedef struct {
    string name;
    int    half;
    bit    exp_ok;
    int    exp_fail;
    bit    exp_req;
  } vec_t;

  logic        clk_sys = 1'b0;
  logic        rst     = 1'b1;
  logic        clk_48m = 1'b0;
  logic        pll_rst_req;
  logic        clk_ok;
  logic [15:0] meas_cnt;
  logic [3:0]  fail_cnt;

  int half_ps = H48M0;
  int n_vec   = 0;
  int n_err   = 0;
  int req_hi  = 0;

  int gap, win_cycles, prev_ok, prev_fail, prev_lo, prev_hi, prev_half, m_fail, reqs_done;

  pll_supervisor dut (
    .clk_30m72_i (clk_sys),
    .rst_30m72_i (rst),
    .clk_48m     (clk_48m),
    .pll_rst_req (pll_rst_req),
    .clk_ok      (clk_ok),
    .meas_cnt    (meas_cnt),
    .fail_cnt    (fail_cnt)
  );

  always #(SYS_HALF) clk_sys = ~clk_sys;

  initial begin
    forever begin
      if (half_ps == 0) begin
        clk_48m = 1'b0;
        #1000;
      end else begin
        #(half_ps) clk_48m = ~clk_48m;
      end
    end
  end

  // Total system cycles the request has been high so far.
  always @(posedge clk_sys) if (pll_rst_req) req_hi <= req_hi + 1;

  task automatic chk(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      if (lo == hi) $display("FAIL %s: got %0d, expected %0d", name, act, lo);
      else          $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int ideal_count(input int cycles, input int half);
    if (half == 0) return 0;
    return $rtoi(real'(cycles * SYS_PERIOD) / real'(2 * half) + 0.5);
  endfunction

  task automatic do_reset(input int half, input bit mid_cycle);
    half_ps = half;
    if (mid_cycle) begin
      #5000 rst = 1'b1;
      #1;
      chk("async rst meas", int'(meas_cnt), 0, 0);
      chk("async rst ok", int'(clk_ok), 0, 0);
      chk("async rst fail", int'(fail_cnt), 0, 0);
      chk("async rst req", int'(pll_rst_req), 0, 0);
      repeat (3) @(posedge clk_sys);
    end else begin
      @(negedge clk_sys) rst = 1'b1;
      repeat (3) @(posedge clk_sys);
    end
    @(negedge clk_sys);
    chk("reset meas", int'(meas_cnt), 0, 0);
    chk("reset ok", int'(clk_ok), 0, 0);
    chk("reset fail", int'(fail_cnt), 0, 0);
    chk("reset req", int'(pll_rst_req), 0, 0);
    rst = 1'b0;
    $display("reset released (half=%0d ps, async=%0d)", half, mid_cycle);
    gap        = 2049;
    win_cycles = 1024;
    prev_ok    = 0;
    prev_fail  = 0;
    prev_lo    = 0;
    prev_hi    = 0;
    prev_half  = half;
    m_fail     = 0;
  endtask

  task automatic apply_window(input string name, input int half, input bit exp_ok,
                              input int exp_fail, input bit exp_req);
    int ideal, lo, hi, tol;
    half_ps = half;
    ideal = ideal_count(win_cycles, half);
    tol   = (half == 0 && prev_half == 0) ? 0 : 8;
    lo    = (ideal > tol) ? ideal - tol : 0;
    hi    = ideal + tol;
    repeat (gap - 1) @(posedge clk_sys);
    @(negedge clk_sys);
    chk({name, " hold meas"}, int'(meas_cnt), prev_lo, prev_hi);
    chk({name, " hold ok"}, int'(clk_ok), prev_ok, prev_ok);
    chk({name, " hold fail"}, int'(fail_cnt), prev_fail, prev_fail);
    chk({name, " hold req"}, int'(pll_rst_req), 0, 0);
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk({name, " meas"}, int'(meas_cnt), lo, hi);
    chk({name, " ok"}, int'(clk_ok), int'(exp_ok), int'(exp_ok));
    chk({name, " fail"}, int'(fail_cnt), exp_fail, exp_fail);
    chk({name, " req"}, int'(pll_rst_req), int'(exp_req), int'(exp_req));
    chk({name, " req cycles"}, req_hi, 16 * reqs_done, 16 * reqs_done);
    $display("window %-10s half=%0d meas=%0d (%0d..%0d) ok=%0d fail=%0d req=%0d",
             name, half, meas_cnt, lo, hi, clk_ok, fail_cnt, pll_rst_req);
    prev_lo   = lo;
    prev_hi   = hi;
    prev_ok   = int'(exp_ok);
    prev_half = half;
    if (exp_req) begin
      prev_fail  = 0;
      reqs_done++;
      gap        = 16 + 4096 + 2048 + 1;
      win_cycles = 1024;
    end else begin
      prev_fail  = exp_fail;
      gap        = 1025;
      win_cycles = 1025;
    end
  endtask

  // Pass/fail and the consecutive-failure rule taken straight from the window count.
  task automatic model_window(input string name, input int half);
    int  ideal;
    bit  pass, req;
    ideal  = ideal_count(win_cycles, half);
    pass   = (ideal >= EXP_NOM - TOL) && (ideal <= EXP_NOM + TOL);
    m_fail = pass ? 0 : ((m_fail < 15) ? m_fail + 1 : 15);
    req    = AUTORESET && !pass && (m_fail >= 3);
    apply_window(name, half, pass, m_fail, req);
    if (req) m_fail = 0;
  endtask

  vec_t tbl [8];

  initial begin
    int sel, half;
    tbl[0] = '{"nominal", H48M0, 1'b1, 0, 1'b0};
    tbl[1] = '{"nominal", H48M0, 1'b1, 0, 1'b0};
    tbl[2] = '{"f48.4", H48M4, 1'b1, 0, 1'b0};
    tbl[3] = '{"f47.0", H47M0, 1'b0, 1, 1'b0};
    tbl[4] = '{"f47.0", H47M0, 1'b0, 2, 1'b0};
    tbl[5] = '{"nominal", H48M0, 1'b1, 0, 1'b0};
    tbl[6] = '{"f47.0", H47M0, 1'b0, 1, 1'b0};
    tbl[7] = '{"nominal", H48M0, 1'b1, 0, 1'b0};
    reqs_done = 0;

    do_reset(H48M0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      apply_window(tbl[i].name, tbl[i].half, tbl[i].exp_ok, tbl[i].exp_fail, tbl[i].exp_req);
    end

    // Reset in the middle of a measurement window.
    repeat (500) @(posedge clk_sys);
    @(negedge clk_sys);
    do_reset(H48M0, 1'b1);
    model_window("post-rst", H48M0);

    // Stopped PLL clock from reset onwards.
    do_reset(0, 1'b0);
    for (int w = 1; w <= (AUTORESET ? 4 : 16); w++) begin
      if (AUTORESET) apply_window("stopped", 0, 1'b0, (w == 4) ? 1 : w, w == 3);
      else           apply_window("stopped", 0, 1'b0, (w > 15) ? 15 : w, 1'b0);
    end
    m_fail = AUTORESET ? 1 : 15;

    for (int i = 0; i < 16; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      half = $urandom_range(10395, 10450);
      else if (sel <= 7) half = $urandom_range(9800, 10100);
      else if (sel == 8) half = $urandom_range(10800, 11200);
      else               half = 0;
      model_window("random", half);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
